// File: rtl/sng_sched_if.sv
// Requester, response and shared-SNG signals of the SNG scheduler.
// slave is the scheduler's view; master is the environment's view.
interface sng_sched_if #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned bsl       = 255,
  parameter int unsigned reg_width = $clog2(bsl)
) ();
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ*reg_width-1:0] val;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [bsl-1:0]            rsp_sbs;
  logic                      err;
  logic                      sng_start;
  logic [reg_width-1:0]      sng_val;
  logic                      sng_done;
  logic [bsl-1:0]            sng_sbs;

  modport slave (
    input  req, val, rsp_ready, sng_done, sng_sbs,
    output gnt, busy, rsp_valid, rsp_id, rsp_sbs, err, sng_start, sng_val
  );

  modport master (
    output req, val, rsp_ready, sng_done, sng_sbs,
    input  gnt, busy, rsp_valid, rsp_id, rsp_sbs, err, sng_start, sng_val
  );
endinterface

// File: rtl/sng_sched.sv
// Round-robin scheduler sharing one stochastic number generator among NREQ requesters.
// All outputs are registered: gnt shows in ISSUE, sng_start in the first WAIT cycle.
module sng_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned bsl       = 255,
  parameter int unsigned reg_width = $clog2(bsl),
  parameter int unsigned TMO       = bsl + 8
) (
  input logic        clk,
  input logic        rst,
  sng_sched_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned WDW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               r_state, w_state_d;
  logic [IDW-1:0]       r_ptr, w_ptr_d;
  logic [IDW-1:0]       r_id, w_id_d;
  logic [WDW-1:0]       r_wdog, w_wdog_d;
  logic                 r_err, w_err_d;
  logic [NREQ-1:0]      r_gnt, w_gnt_d;
  logic                 r_sng_start, w_sng_start_d;
  logic [reg_width-1:0] r_sng_val, w_sng_val_d;
  logic                 r_rsp_valid, w_rsp_valid_d;
  logic [IDW-1:0]       r_rsp_id, w_rsp_id_d;
  logic [bsl-1:0]       r_rsp_sbs, w_rsp_sbs_d;

  logic                 w_any;
  logic [IDW-1:0]       w_sel;
  logic [IDW:0]         w_idx;
  logic [IDW-1:0]       w_ptr_inc;

  // Explicit wrap so non-power-of-two NREQ stays in range.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_any && bus.req[w_idx[IDW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[IDW-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_id_d        = r_id;
    w_wdog_d      = r_wdog;
    w_err_d       = r_err;
    w_gnt_d       = '0;
    w_sng_start_d = 1'b0;
    w_sng_val_d   = r_sng_val;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_id_d    = r_rsp_id;
    w_rsp_sbs_d   = r_rsp_sbs;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_d     = NREQ'(1) << w_sel;
          w_id_d      = w_sel;
          w_sng_val_d = bus.val[int'(w_sel) * reg_width +: reg_width];
          w_state_d   = StIssue;
        end
      end
      StIssue: begin
        w_sng_start_d = 1'b1;
        w_wdog_d      = '0;
        w_state_d     = StWait;
      end
      StWait: begin
        w_wdog_d = r_wdog + 1'b1;
        // wdog==0 marks the first WAIT cycle, where done may be left over from the last run.
        if (bus.sng_done && (r_wdog != '0)) begin
          w_rsp_sbs_d   = bus.sng_sbs;
          w_rsp_id_d    = r_id;
          w_rsp_valid_d = 1'b1;
          w_state_d     = StResp;
        end else if (r_wdog == WDW'(TMO - 1)) begin
          w_err_d   = 1'b1;
          w_ptr_d   = w_ptr_inc;
          w_state_d = StIdle;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_ptr_d       = w_ptr_inc;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_id        <= '0;
      r_wdog      <= '0;
      r_err       <= 1'b0;
      r_gnt       <= '0;
      r_sng_start <= 1'b0;
      r_sng_val   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sbs   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_id        <= w_id_d;
      r_wdog      <= w_wdog_d;
      r_err       <= w_err_d;
      r_gnt       <= w_gnt_d;
      r_sng_start <= w_sng_start_d;
      r_sng_val   <= w_sng_val_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_id    <= w_rsp_id_d;
      r_rsp_sbs   <= w_rsp_sbs_d;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state != StIdle);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sbs   = r_rsp_sbs;
  assign bus.err       = r_err;
  assign bus.sng_start = r_sng_start;
  assign bus.sng_val   = r_sng_val;
endmodule
